// File: rtl/uart_rx_oversampled_if.sv
// Serial receive bundle: oversampled tick and raw line in, byte/strobes/status out.
`timescale 1ns/1ps
interface uart_rx_oversampled_if;
  logic       tick;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport master (
    output tick,
    output rx,
    input  data,
    input  valid,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  tick,
    input  rx,
    output data,
    output valid,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver driven by an oversampled baud tick; samples each bit at
// mid-bit, strobes good bytes on valid and bad stop bits on frame_err.
`timescale 1ns/1ps
module uart_rx_oversampled #(
  parameter int OVERSAMPLING = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_rx_oversampled_if.slave   bus
);

  localparam int CNT_W = (OVERSAMPLING > 2) ? $clog2(OVERSAMPLING) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLING / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLING - 1);

  generate
    if ((OVERSAMPLING < 4) || (OVERSAMPLING % 2 != 0)) begin : g_bad_param
      $error("OVERSAMPLING must be even and at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             rx_meta_q, rx_s_q;
  logic             rel_q;
  logic             tick_en;

  // Ignore a tick that coincides with the first clock after reset release.
  assign tick_en = bus.tick & rel_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rel_q     <= 1'b0;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
      rel_q     <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    if (tick_en) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_d = S_START;
            cnt_d   = '0;
          end
        end

        // Confirm the start bit half a bit in; a high line here was a glitch.
        S_START: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_HALF) begin
            if (rx_s_q) begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end else begin
              state_d = S_DATA;
              cnt_d   = '0;
              idx_d   = '0;
            end
          end
        end

        S_DATA: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            shift_d = {rx_s_q, shift_q[7:1]};
            cnt_d   = '0;
            idx_d   = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_d = S_STOP;
            end
          end
        end

        S_STOP: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (rx_s_q) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = S_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_BREAK;
            end
          end
        end

        // A held-low line reports one error and then waits for idle.
        S_BREAK: begin
          if (rx_s_q) begin
            state_d = S_IDLE;
          end
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: table of frames plus hand-written corner
// sequences, with a queue scoreboard consuming valid/frame_err strobes.
`timescale 1ns/1ps
module tb_uart_rx_oversampled;

  localparam int TICK_DIV = 13;
  localparam int BIT_CLKS = 8 * TICK_DIV;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   tdiv  = 0;

  uart_rx_oversampled_if u_if ();

  uart_rx_oversampled #(.OVERSAMPLING(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  always #5 clk = ~clk;

  // Baud tick source: one pulse every TICK_DIV clocks, enable tied high.
  always @(posedge clk) begin
    if (tdiv == TICK_DIV - 1) begin
      tdiv      <= 0;
      u_if.tick <= 1'b1;
    end else begin
      tdiv      <= tdiv + 1;
      u_if.tick <= 1'b0;
    end
  end

  typedef struct {
    logic       err;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [7:0] byte_v;
    logic       stop;
    int         gap_bits;
    logic       exp_err;
    logic [7:0] exp_data;
  } vec_t;

  exp_t       sb_q[$];
  logic [7:0] model_last = 8'h00;
  logic       prev_strobe = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_strobe) begin
        total++;
        if (u_if.valid || u_if.frame_err) begin
          bad++;
          $display("FAIL strobe_width: valid=%0b frame_err=%0b, required both 0 one clk after a strobe",
                   u_if.valid, u_if.frame_err);
        end
      end
      if (u_if.valid || u_if.frame_err) begin
        exp_t e;
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_strobe: valid=%0b frame_err=%0b data=%02h, required no strobe",
                   u_if.valid, u_if.frame_err, u_if.data);
        end else begin
          e = sb_q.pop_front();
          if ({u_if.valid, u_if.frame_err} !== {~e.err, e.err} || u_if.data !== e.data) begin
            bad++;
            $display("FAIL frame_out: valid=%0b frame_err=%0b data=%02h, required valid=%0b frame_err=%0b data=%02h",
                     u_if.valid, u_if.frame_err, u_if.data, ~e.err, e.err, e.data);
          end
        end
      end
      prev_strobe <= u_if.valid | u_if.frame_err;
    end else begin
      prev_strobe <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic hold_bit(input logic v);
    u_if.rx = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic push_exp(input logic err, input logic [7:0] b);
    exp_t e;
    e.err = err;
    e.data = err ? model_last : b;
    if (!err) model_last = b;
    sb_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
    hold_bit(stop);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: %0d frames outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  vec_t vecs[8];

  initial begin
    logic seen_busy;

    vecs[0] = '{8'h55, 1'b1, 3, 1'b0, 8'h55};
    vecs[1] = '{8'hA5, 1'b1, 0, 1'b0, 8'hA5};
    vecs[2] = '{8'h3C, 1'b1, 3, 1'b0, 8'h3C};
    vecs[3] = '{8'h00, 1'b1, 0, 1'b0, 8'h00};
    vecs[4] = '{8'hFF, 1'b1, 1, 1'b0, 8'hFF};
    vecs[5] = '{8'h5A, 1'b0, 2, 1'b1, 8'hFF};
    vecs[6] = '{8'h81, 1'b1, 2, 1'b0, 8'h81};
    vecs[7] = '{8'hC6, 1'b1, 0, 1'b0, 8'hC6};

    u_if.rx = 1'b1;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_data", {24'd0, u_if.data}, 32'h0);
    chk("reset_flags", {29'd0, u_if.valid, u_if.frame_err, u_if.busy}, 32'h0);
    rst = 1'b0;
    repeat (2 * BIT_CLKS) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      push_exp(vecs[i].exp_err, vecs[i].byte_v);
      if (vecs[i].exp_err != 1'b0 && model_last !== vecs[i].exp_data) begin
        $display("note: vector %0d expected data differs from running model", i);
      end
      send_frame(vecs[i].byte_v, vecs[i].stop);
      for (int g = 0; g < vecs[i].gap_bits; g++) hold_bit(1'b1);
      if (vecs[i].gap_bits > 0) begin
        drain(4 * BIT_CLKS);
        chk("table_data", {24'd0, u_if.data}, {24'd0, vecs[i].exp_err ? model_last : vecs[i].exp_data});
      end
    end
    hold_bit(1'b1);
    drain(4 * BIT_CLKS);
    chk("idle_busy", {31'd0, u_if.busy}, 32'h0);

    // Glitch: two tick periods low must not start a frame.
    seen_busy = 1'b0;
    u_if.rx = 1'b0;
    repeat (2 * TICK_DIV) begin
      @(negedge clk);
      seen_busy |= u_if.busy;
    end
    u_if.rx = 1'b1;
    repeat (6 * TICK_DIV) begin
      @(negedge clk);
      seen_busy |= u_if.busy;
    end
    chk("glitch_busy_pulse", {31'd0, seen_busy}, 32'h1);
    chk("glitch_busy_end", {31'd0, u_if.busy}, 32'h0);
    chk("glitch_data", {24'd0, u_if.data}, 32'hC6);

    // Framing error followed by a long break.
    hold_bit(1'b1);
    push_exp(1'b0, 8'h12);
    send_frame(8'h12, 1'b1);
    push_exp(1'b1, 8'hFF);
    send_frame(8'hFF, 1'b0);
    repeat (20) hold_bit(1'b0);
    drain(BIT_CLKS);
    chk("break_busy", {31'd0, u_if.busy}, 32'h1);
    chk("break_data", {24'd0, u_if.data}, 32'h12);
    u_if.rx = 1'b1;
    repeat (3 * TICK_DIV) @(negedge clk);
    chk("break_exit_busy", {31'd0, u_if.busy}, 32'h0);
    hold_bit(1'b1);
    push_exp(1'b0, 8'h81);
    send_frame(8'h81, 1'b1);
    hold_bit(1'b1);
    drain(4 * BIT_CLKS);
    chk("after_break_data", {24'd0, u_if.data}, 32'h81);

    // Asynchronous reset in the middle of bit 3 of 0xC3.
    hold_bit(1'b0);
    hold_bit(1'b1);
    hold_bit(1'b1);
    hold_bit(1'b0);
    u_if.rx = 1'b0;
    repeat (BIT_CLKS / 2) @(negedge clk);
    chk("mid_frame_busy", {31'd0, u_if.busy}, 32'h1);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_data", {24'd0, u_if.data}, 32'h0);
    chk("async_rst_flags", {29'd0, u_if.valid, u_if.frame_err, u_if.busy}, 32'h0);
    model_last = 8'h00;
    u_if.rx = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    repeat (2 * BIT_CLKS) @(negedge clk);
    chk("post_rst_busy", {31'd0, u_if.busy}, 32'h0);
    push_exp(1'b0, 8'h7E);
    send_frame(8'h7E, 1'b1);
    hold_bit(1'b1);
    drain(4 * BIT_CLKS);
    chk("post_rst_data", {24'd0, u_if.data}, 32'h7E);

    // Reset held while the line toggles randomly.
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 200; i++) begin
      u_if.rx = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rst_hold_outputs", {20'd0, u_if.data, 1'b0, u_if.valid, u_if.frame_err, u_if.busy}, 32'h0);
    end
    u_if.rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2 * BIT_CLKS) @(negedge clk);
    chk("final_queue_empty", sb_q.size(), 32'h0);
    chk("final_busy", {31'd0, u_if.busy}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
